// File: rtl/reg_spill_if.sv
// ---------------------------------------------------------------------------
// reg_spill_if
// Bundle of the control, register-file and data-memory signals exchanged
// between the context save/restore engine and its surroundings.
//   slave  : the engine side (drives busy/done, addresses, enables, write data)
//   master : the environment side (drives starts, base address, read data)
// Signals:
//   start_save / start_restore  operation requests
//   base_addr                   memory base address for the operation
//   busy / done                 progress status and completion pulse
//   rf_rd_addr / rf_rd_data     register-file read port
//   rf_wr_en / rf_wr_addr / rf_wr_data   register-file write port
//   mem_addr / mem_wr_en / mem_wr_data / mem_rd_data   data-memory port
// ---------------------------------------------------------------------------
interface reg_spill_if #(
    parameter int RA_W   = 4,
    parameter int DATA_W = 8,
    parameter int MA_W   = 8
);
    logic              start_save;
    logic              start_restore;
    logic [MA_W-1:0]   base_addr;
    logic              busy;
    logic              done;
    logic [RA_W-1:0]   rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [RA_W-1:0]   rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [MA_W-1:0]   mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  start_save, start_restore, base_addr, rf_rd_data, mem_rd_data,
        output busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               mem_addr, mem_wr_en, mem_wr_data
    );

    modport master (
        output start_save, start_restore, base_addr, rf_rd_data, mem_rd_data,
        input  busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/reg_spill_ctrl.sv
// ---------------------------------------------------------------------------
// reg_spill_ctrl
// Context save/restore engine. SAVE copies r0..r(NUM_REGS-1) to NUM_REGS
// consecutive data-memory bytes starting at base_addr; RESTORE copies them
// back. One register moves per cycle; a one-cycle DONE state follows.
// Ports:
//   clk    single clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    reg_spill_if.slave (starts, status, register-file and memory ports)
// All outputs decode from registered state; the only input-to-output paths
// are the read-data to write-data pass-throughs.
// ---------------------------------------------------------------------------
module reg_spill_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int RA_W     = 4,
    parameter int DATA_W   = 8,
    parameter int MA_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    reg_spill_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [RA_W-1:0] LAST_IDX = RA_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [RA_W-1:0]   idx_q, idx_d;
    logic [MA_W-1:0]   base_q, base_d;

    logic              busy_s;
    logic              done_s;
    logic [RA_W-1:0]   rf_rd_addr_s;
    logic              rf_wr_en_s;
    logic [RA_W-1:0]   rf_wr_addr_s;
    logic [DATA_W-1:0] rf_wr_data_s;
    logic [MA_W-1:0]   mem_addr_s;
    logic              mem_wr_en_s;
    logic [DATA_W-1:0] mem_wr_data_s;
    logic [MA_W-1:0]   xfer_addr_s;

    // Memory address of the current transfer; idx is zero-extended and the
    // sum wraps modulo 2^MA_W.
    assign xfer_addr_s = base_q + MA_W'(idx_q);

    // State, index and latched base registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        base_d        = base_q;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        rf_rd_addr_s  = '0;
        rf_wr_en_s    = 1'b0;
        rf_wr_addr_s  = '0;
        rf_wr_data_s  = '0;
        mem_addr_s    = '0;
        mem_wr_en_s   = 1'b0;
        mem_wr_data_s = '0;
        case (state_q)
            ST_IDLE: begin
                // SAVE has priority when both requests arrive together.
                if (bus.start_save) begin
                    state_d = ST_SAVE;
                    idx_d   = '0;
                    base_d  = bus.base_addr;
                end else if (bus.start_restore) begin
                    state_d = ST_RESTORE;
                    idx_d   = '0;
                    base_d  = bus.base_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                busy_s        = 1'b1;
                rf_rd_addr_s  = idx_q;
                mem_addr_s    = xfer_addr_s;
                mem_wr_en_s   = 1'b1;
                mem_wr_data_s = bus.rf_rd_data;
                // Index holds at its terminal value on the final transfer.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + RA_W'(1);
                end
            end
            ST_RESTORE: begin
                busy_s       = 1'b1;
                mem_addr_s   = xfer_addr_s;
                rf_wr_en_s   = 1'b1;
                rf_wr_addr_s = idx_q;
                rf_wr_data_s = bus.mem_rd_data;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + RA_W'(1);
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_s;
    assign bus.done        = done_s;
    assign bus.rf_rd_addr  = rf_rd_addr_s;
    assign bus.rf_wr_en    = rf_wr_en_s;
    assign bus.rf_wr_addr  = rf_wr_addr_s;
    assign bus.rf_wr_data  = rf_wr_data_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wr_en   = mem_wr_en_s;
    assign bus.mem_wr_data = mem_wr_data_s;

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_spill_ctrl
// Bench for reg_spill_ctrl: models the register file and data memory around
// the engine, drives a table of operations plus random ones, and compares
// per-cycle outputs and final storage contents with a copy-loop reference.
// ---------------------------------------------------------------------------
module tb_reg_spill_ctrl;

    logic clk;
    logic reset;

    reg_spill_if #(.RA_W(4), .DATA_W(8), .MA_W(8)) bus ();

    reg_spill_ctrl #(.NUM_REGS(16), .RA_W(4), .DATA_W(8), .MA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Storage surrounding the engine; only the clocked block below writes it.
    logic [7:0] rf_m   [16];
    logic [7:0] mem_m  [256];
    logic [7:0] rf_load  [16];
    logic [7:0] mem_load [256];
    logic       load_req;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_rd_data  = rf_m[bus.rf_rd_addr];
    assign bus.mem_rd_data = mem_m[bus.mem_addr];

    // Register file / memory write ports plus a whole-array preload path.
    always @(posedge clk) begin
        if (load_req) begin
            rf_m  <= rf_load;
            mem_m <= mem_load;
        end else begin
            if (bus.rf_wr_en)  rf_m[bus.rf_wr_addr] <= bus.rf_wr_data;
            if (bus.mem_wr_en) mem_m[bus.mem_addr]  <= bus.mem_wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},       32'(bus.busy),        32'd0);
        check({tag, "_done"},       32'(bus.done),        32'd0);
        check({tag, "_rf_wr_en"},   32'(bus.rf_wr_en),    32'd0);
        check({tag, "_mem_wr_en"},  32'(bus.mem_wr_en),   32'd0);
        check({tag, "_rf_rd_addr"}, 32'(bus.rf_rd_addr),  32'd0);
        check({tag, "_rf_wr_addr"}, 32'(bus.rf_wr_addr),  32'd0);
        check({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data),  32'd0);
        check({tag, "_mem_addr"},   32'(bus.mem_addr),    32'd0);
        check({tag, "_mem_wr_data"},32'(bus.mem_wr_data), 32'd0);
    endtask

    // One operation: reference model is a plain copy loop over a snapshot.
    task automatic run_op(input bit ss, input bit sr, input logic [7:0] base,
                          input bit mid, input bit hold,
                          input bit exp_run, input bit exp_save);
        logic [7:0] rf_snap [16];
        logic [7:0] mem_snap [256];
        logic [7:0] rf_exp [16];
        logic [7:0] mem_exp [256];
        logic [7:0] a;
        int bad;
        bit found;
        rf_snap = rf_m;  mem_snap = mem_m;
        rf_exp  = rf_m;  mem_exp  = mem_m;
        if (exp_run) begin
            for (int k = 0; k < 16; k++) begin
                a = 8'(base + k);
                if (exp_save) mem_exp[a] = rf_snap[k];
                else          rf_exp[k]  = mem_snap[a];
            end
        end
        @(negedge clk);
        bus.start_save    = ss;
        bus.start_restore = sr;
        bus.base_addr     = base;
        if (!exp_run) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                bus.start_save = 1'b0; bus.start_restore = 1'b0;
                check("noop_busy", 32'(bus.busy), 32'd0);
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    bus.start_save = 1'b0; bus.start_restore = 1'b0;
                    bus.base_addr  = 8'($urandom);
                end
                if (mid && k == 5) bus.start_restore = 1'b1;
                if (mid && k == 6) bus.start_restore = 1'b0;
                a = 8'(base + k);
                check("xfer_busy",      32'(bus.busy),      32'd1);
                check("xfer_done",      32'(bus.done),      32'd0);
                check("xfer_mem_addr",  32'(bus.mem_addr),  32'(a));
                check("xfer_mem_wr_en", 32'(bus.mem_wr_en), 32'(exp_save));
                check("xfer_rf_wr_en",  32'(bus.rf_wr_en),  32'(!exp_save));
                check("xfer_rf_rd_addr",32'(bus.rf_rd_addr), exp_save ? 32'(k) : 32'd0);
                check("xfer_rf_wr_addr",32'(bus.rf_wr_addr), exp_save ? 32'd0 : 32'(k));
                check("xfer_mem_wr_data",32'(bus.mem_wr_data), exp_save ? 32'(rf_snap[k]) : 32'd0);
                check("xfer_rf_wr_data",32'(bus.rf_wr_data), exp_save ? 32'd0 : 32'(mem_snap[a]));
            end
            @(negedge clk);
            check("done_pulse", 32'(bus.done), 32'd1);
            check("done_busy",  32'(bus.busy), 32'd0);
            check("done_wr_en", 32'({bus.rf_wr_en, bus.mem_wr_en}), 32'd0);
            check("done_addr",  32'(bus.mem_addr), 32'd0);
            if (hold) begin
                bus.start_save = 1'b1;
                bus.base_addr  = base;
            end
            @(negedge clk);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            if (hold) begin
                @(negedge clk);
                check("hold_accept_busy", 32'(bus.busy), 32'd1);
                bus.start_save = 1'b0;
                found = 1'b0;
                for (int c = 0; c < 40 && !found; c++) begin
                    @(negedge clk);
                    if (bus.done) found = 1'b1;
                end
                check("hold_done_seen", 32'(found), 32'd1);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++)  if (rf_m[i]  !== rf_exp[i])  bad++;
        check("rf_contents", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem_m[i] !== mem_exp[i]) bad++;
        check("mem_contents", 32'(bad), 32'd0);
    endtask

    typedef struct {
        bit         ss;
        bit         sr;
        logic [7:0] base;
        bit         mid;
        bit         hold;
        bit         exp_run;
        bit         exp_save;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] orig [16];
        logic [7:0] rf_snap [16];
        logic [7:0] mem_snap [256];
        logic [7:0] b;
        int bad;
        bit s1, s2;

        tbl[0] = '{1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        load_req = 1'b0;
        bus.start_save = 1'b0;
        bus.start_restore = 1'b0;
        bus.base_addr = 8'h00;
        for (int i = 0; i < 16; i++)  rf_load[i]  = 8'(8'h10 + i);
        for (int i = 0; i < 256; i++) mem_load[i] = 8'($urandom);
        for (int i = 0; i < 16; i++)  mem_load[8'h80 + i] = 8'(8'hA0 + i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        do_load();

        for (int t = 0; t < 7; t++)
            run_op(tbl[t].ss, tbl[t].sr, tbl[t].base, tbl[t].mid, tbl[t].hold,
                   tbl[t].exp_run, tbl[t].exp_save);

        // Reset landing mid-RESTORE: r0..r4 restored, the rest untouched.
        for (int i = 0; i < 16; i++)  rf_load[i]  = 8'($urandom);
        for (int i = 0; i < 256; i++) mem_load[i] = 8'($urandom);
        do_load();
        rf_snap = rf_m; mem_snap = mem_m;
        b = 8'h90;
        @(negedge clk);
        bus.start_restore = 1'b1;
        bus.base_addr = b;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.start_restore = 1'b0;
            if (k == 4) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check_zero("midreset");
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (rf_m[i] !== ((i < 5) ? mem_snap[8'(b + i)] : rf_snap[i])) bad++;
        check("midreset_rf", 32'(bad), 32'd0);
        run_op(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Save, scramble registers, restore from the same base.
        orig = rf_m;
        run_op(1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) rf_load[i] = ~orig[i];
        mem_load = mem_m;
        do_load();
        run_op(1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf_m[i] !== orig[i]) bad++;
        check("roundtrip_rf", 32'(bad), 32'd0);

        // Random operations against the copy-loop model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++)  rf_load[i]  = 8'($urandom);
            for (int i = 0; i < 256; i++) mem_load[i] = 8'($urandom);
            do_load();
            s1 = 1'($urandom_range(1, 0));
            s2 = 1'($urandom_range(1, 0));
            run_op(s1, s2, 8'($urandom), 1'b0, 1'b0, s1 | s2, s1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
